// File: rtl/load_store_unit_pkg.sv
// Shared load/store unit types: store widths, byte strobes and the
// store drain FSM state encoding.
package load_store_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } store_width_t;

  typedef logic [STRB_W-1:0] store_strobe_t;

  typedef enum logic [1:0] {
    DRAIN_IDLE      = 2'b00,
    DRAIN_REQUEST   = 2'b01,
    DRAIN_WAIT_DONE = 2'b10
  } drain_state_t;

endpackage

// File: rtl/store_lane_aligner.sv
// Combinational lane aligner: turns a right-aligned store (width, address
// low bits, data) into byte strobes and lane-replicated write data, and
// flags accesses that cross their natural alignment.
//   offset     in   address[1:0]
//   width      in   store width
//   data       in   right-aligned store data
//   strobe     out  byte enables
//   lane_data  out  data replicated onto every lane it may occupy
//   misaligned out  access is not naturally aligned
module store_lane_aligner
  import load_store_unit_pkg::*;
(
  input  logic [1:0]        offset,
  input  store_width_t      width,
  input  logic [DATA_W-1:0] data,
  output store_strobe_t     strobe,
  output logic [DATA_W-1:0] lane_data,
  output logic              misaligned
);

  always_comb begin
    strobe     = '0;
    lane_data  = data;
    misaligned = 1'b0;
    case (width)
      BYTE: begin
        strobe    = store_strobe_t'(4'b0001 << offset);
        lane_data = {4{data[7:0]}};
      end
      HALF: begin
        strobe     = offset[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{data[15:0]}};
        misaligned = offset[0];
      end
      WORD: begin
        strobe     = 4'b1111;
        misaligned = (offset != 2'b00);
      end
      // Unencoded width cannot be written safely; drop it as misaligned.
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_drain_controller.sv
// Store drain controller: pops committed entries from the store buffer head
// and issues them as word-aligned, byte-strobed memory writes, retrying
// failed writes up to MAX_RETRY extra times.
//   clk_i, rst_n_i                          clock, async active-low reset
//   buffer_empty_i/valid_i/address_i/
//   data_i/width_i                          store buffer head entry
//   pull_request_o                          pop pulse (combinational, IDLE only)
//   mem_request_o/address_o/data_o/strobe_o write request payload
//   mem_ready_i, mem_done_i, mem_error_i    memory handshake and completion
//   misaligned_o, write_error_o             drop-reason pulses
//   idle_o                                  no store in flight, buffer empty
module store_drain_controller
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              buffer_empty_i,
  input  logic              buffer_valid_i,
  input  logic [ADDR_W-1:0] buffer_address_i,
  input  logic [DATA_W-1:0] buffer_data_i,
  input  store_width_t      buffer_width_i,
  output logic              pull_request_o,
  output logic              mem_request_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_data_o,
  output store_strobe_t     mem_strobe_o,
  input  logic              mem_ready_i,
  input  logic              mem_done_i,
  input  logic              mem_error_i,
  output logic              misaligned_o,
  output logic              write_error_o,
  output logic              idle_o
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  drain_state_t        state, state_next;
  logic [RETRY_W-1:0]  retry, retry_next;
  logic                request_next, misaligned_next, write_error_next;
  logic                latch;
  store_strobe_t       lane_strobe;
  logic [DATA_W-1:0]   lane_data;
  logic                lane_misaligned;

  store_lane_aligner u_aligner (
    .offset     (buffer_address_i[1:0]),
    .width      (buffer_width_i),
    .data       (buffer_data_i),
    .strobe     (lane_strobe),
    .lane_data  (lane_data),
    .misaligned (lane_misaligned)
  );

  // Pop is gated by reset so nothing leaves the buffer while held in reset.
  assign pull_request_o = rst_n_i & (state == DRAIN_IDLE) & ~buffer_empty_i & buffer_valid_i;
  assign idle_o         = (state == DRAIN_IDLE) & buffer_empty_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= DRAIN_IDLE;
      retry <= '0;
    end else begin
      state <= state_next;
      retry <= retry_next;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_next       = state;
    retry_next       = retry;
    request_next     = 1'b0;
    misaligned_next  = 1'b0;
    write_error_next = 1'b0;
    latch            = 1'b0;
    case (state)
      DRAIN_IDLE: begin
        if (pull_request_o) begin
          latch = 1'b1;
          if (lane_misaligned) begin
            misaligned_next = 1'b1;
          end else begin
            state_next   = DRAIN_REQUEST;
            request_next = 1'b1;
            retry_next   = '0;
          end
        end
      end
      DRAIN_REQUEST: begin
        if (mem_ready_i) state_next   = DRAIN_WAIT_DONE;
        else             request_next = 1'b1;
      end
      DRAIN_WAIT_DONE: begin
        if (mem_done_i) begin
          if (!mem_error_i) begin
            state_next = DRAIN_IDLE;
          end else if (retry < RETRY_W'(MAX_RETRY)) begin
            // Only incremented below the limit, so the count never wraps.
            retry_next   = retry + RETRY_W'(1);
            state_next   = DRAIN_REQUEST;
            request_next = 1'b1;
          end else begin
            write_error_next = 1'b1;
            state_next       = DRAIN_IDLE;
          end
        end
      end
      default: state_next = DRAIN_IDLE;
    endcase
  end

  // Registered outputs; the payload holds the popped entry across retries.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_request_o <= 1'b0;
      misaligned_o  <= 1'b0;
      write_error_o <= 1'b0;
      mem_address_o <= '0;
      mem_data_o    <= '0;
      mem_strobe_o  <= '0;
    end else begin
      mem_request_o <= request_next;
      misaligned_o  <= misaligned_next;
      write_error_o <= write_error_next;
      if (latch) begin
        mem_address_o <= {buffer_address_i[ADDR_W-1:2], 2'b00};
        mem_data_o    <= lane_data;
        mem_strobe_o  <= lane_strobe;
      end
    end
  end

endmodule
